// File: rtl/arith_range_update.sv
// rtl/arith_range_update.sv - AV1 arithmetic encoder range-update stage

// Combinational 16x16 unsigned multiplier shared across the encoder datapath.
module mult16x16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);
  // Full-width product, both operands zero-extended.
  always_comb begin
    p_o = {16'b0, a_i} * {16'b0, b_i};
  end
endmodule

module arith_range_update #(
  parameter int RANGE_WIDTH = 16,
  parameter int PROB_SHIFT  = 6,
  parameter int MIN_PROB    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_init,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RANGE_WIDTH-1:0] in_fl,
  input  logic [RANGE_WIDTH-1:0] in_fh,
  input  logic [4:0]             in_s,
  input  logic [4:0]             in_nsyms,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RANGE_WIDTH-1:0] out_low_add,
  output logic [3:0]             out_shift,
  output logic [RANGE_WIDTH-1:0] out_range,
  output logic                   out_err
);

  localparam logic [RANGE_WIDTH-1:0] RNG_INIT   = RANGE_WIDTH'(1) << (RANGE_WIDTH - 1);
  localparam int                     PROD_SHIFT = 7 - PROB_SHIFT;
  localparam logic [31:0]            MIN_PROB_W = 32'(MIN_PROB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [RANGE_WIDTH-1:0] rng_q, rng_d;
  logic [RANGE_WIDTH-1:0] fl_q, fh_q;
  logic [4:0]             s_q, n_q;
  logic [RANGE_WIDTH-1:0] low_add_q, range_q;
  logic [3:0]             shift_q;
  logic                   err_q;
  logic                   latch_en, calc_en;

  logic [31:0]            p_u, p_v;
  logic [RANGE_WIDTH-1:0] u_c, v_c, r_c, low_add_c, range_c;
  logic [3:0]             msb_idx, shift_c;
  logic                   err_c;

  // Interval bound products: rng's top byte times the scaled-down CDF bounds.
  mult16x16 u_mul_u (
    .a_i(16'(rng_q >> 8)),
    .b_i(16'(fl_q >> PROB_SHIFT)),
    .p_o(p_u)
  );

  mult16x16 u_mul_v (
    .a_i(16'(rng_q >> 8)),
    .b_i(16'(fh_q >> PROB_SHIFT)),
    .p_o(p_v)
  );

  // Bounds u/v, low increment and the raw (pre-normalization) range r.
  always_comb begin
    u_c = RANGE_WIDTH'((p_u >> PROD_SHIFT)
                       + MIN_PROB_W * (32'(n_q) - (32'(s_q) - 32'd1)));
    v_c = RANGE_WIDTH'((p_v >> PROD_SHIFT)
                       + MIN_PROB_W * (32'(n_q) - 32'(s_q)));
    if (fl_q < RNG_INIT) begin
      low_add_c = rng_q - u_c;
      r_c       = u_c - v_c;
    end else begin
      // First symbol: the lower bound sits at the top of the interval.
      low_add_c = '0;
      r_c       = rng_q - v_c;
    end
  end

  // Normalize r so its msb lands in the top bit; a zero r flags an illegal CDF.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < RANGE_WIDTH; i++) begin
      if (r_c[i]) msb_idx = 4'(i);
    end
    err_c   = (r_c == '0);
    shift_c = err_c ? 4'd0 : (4'(RANGE_WIDTH - 1) - msb_idx);
    range_c = r_c << shift_c;
  end

  // Next-state, handshakes and rng update.
  always_comb begin
    state_d   = state_q;
    rng_d     = rng_q;
    latch_en  = 1'b0;
    calc_en   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          latch_en = 1'b1;
          state_d  = S_CALC;
        end else if (in_init) begin
          rng_d = RNG_INIT;
        end
      end
      S_CALC: begin
        calc_en = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!err_q) rng_d = range_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, symbol operands and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rng_q     <= RNG_INIT;
      fl_q      <= '0;
      fh_q      <= '0;
      s_q       <= '0;
      n_q       <= '0;
      low_add_q <= '0;
      range_q   <= '0;
      shift_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rng_q   <= rng_d;
      if (latch_en) begin
        fl_q <= in_fl;
        fh_q <= in_fh;
        s_q  <= in_s;
        n_q  <= in_nsyms - 5'd1;
      end
      if (calc_en) begin
        low_add_q <= low_add_c;
        range_q   <= range_c;
        shift_q   <= shift_c;
        err_q     <= err_c;
      end
    end
  end

  assign out_low_add = low_add_q;
  assign out_range   = range_q;
  assign out_shift   = shift_q;
  assign out_err     = err_q;

endmodule
